// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  // Payload handed to the decoder: fetch address plus instruction word
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding buffer used while the decoder stalls.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  logic   i_clear,
  input  if_id_t i_data,
  output if_id_t o_data,
  output logic   o_full
);

  if_id_t r_data;
  logic   r_full;

  // Clear wins so a redirect never leaves a stale entry behind
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_clear)     r_full <= 1'b0;
      else if (i_push) r_full <= 1'b1;
      else if (i_pop)  r_full <= 1'b0;
      if (i_push && !i_clear) r_data <= i_data;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one outstanding ibus fetch, feeds ID via a skid-buffered register.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = XLEN,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ibus_req_valid,
  output logic [PC_W-1:0]   ibus_req_addr,
  input  logic              ibus_resp_valid,
  input  logic [INST_W-1:0] ibus_resp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_id_valid,
  input  logic              if_id_ready,
  output if_id_t            if_id_state
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]       perf_fetched,
  output logic [63:0]       perf_stall
`endif
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_req_valid;
  logic [PC_W-1:0] r_req_addr;
  logic            r_out_valid;
  if_id_t          r_out;

  logic            w_retire;
  logic            w_req_hold;
  logic            w_loadable;
  logic            w_accept_resp;
  logic            w_skid_full;
  logic            w_skid_push;
  logic            w_skid_pop;
  logic            w_skid_full_nxt;
  if_id_t          w_skid_data;
  if_id_t          w_resp_pkt;
  logic [PC_W-1:0] w_redir_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_req_valid_nxt;
  logic [PC_W-1:0] w_req_addr_nxt;

  assign w_retire      = r_req_valid && ibus_resp_valid;
  assign w_req_hold    = r_req_valid && !ibus_resp_valid;
  assign w_loadable    = !r_out_valid || if_id_ready;
  // Only a FETCH-state response with no redirect is kept
  assign w_accept_resp = w_retire && !redirect_valid && (r_state == FETCH);

  // The skid is only full while no request is outstanding, so push and pop never overlap
  assign w_skid_push     = w_accept_resp && !w_loadable;
  assign w_skid_pop      = w_skid_full && w_loadable && !redirect_valid;
  assign w_skid_full_nxt = !redirect_valid && (w_skid_push || (w_skid_full && !w_skid_pop));

  assign w_resp_pkt.pc   = r_req_addr;
  assign w_resp_pkt.inst = ibus_resp_data;

  assign w_redir_pc = redirect_pc & ~PC_W'(3);
  assign w_pc_nxt   = redirect_valid ? w_redir_pc :
                      w_accept_resp  ? r_pc + PC_W'(4) : r_pc;

  // FLUSH implies an outstanding request, so request intent reduces to hold-or-skid-free
  assign w_req_valid_nxt = w_req_hold || !w_skid_full_nxt;
  assign w_req_addr_nxt  = w_req_hold ? r_req_addr : w_pc_nxt;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_skid_push),
    .i_pop   (w_skid_pop),
    .i_clear (redirect_valid),
    .i_data  (w_resp_pkt),
    .o_data  (w_skid_data),
    .o_full  (w_skid_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_addr  <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_addr  <= w_req_addr_nxt;

      case (r_state)
        FETCH:   if (redirect_valid && w_req_hold) r_state <= FLUSH;
        FLUSH:   if (w_retire) r_state <= FETCH;
        default: r_state <= FETCH;
      endcase

      if (redirect_valid) begin
        r_out_valid <= 1'b0;
      end else if (w_skid_pop) begin
        r_out       <= w_skid_data;
        r_out_valid <= 1'b1;
      end else if (w_accept_resp && w_loadable) begin
        r_out       <= w_resp_pkt;
        r_out_valid <= 1'b1;
      end else if (if_id_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign ibus_req_valid = r_req_valid;
  assign ibus_req_addr  = r_req_addr;
  assign if_id_valid    = r_out_valid;
  assign if_id_state    = r_out;

`ifdef FETCH_PERF_EN
  logic [63:0] r_perf_fetched;
  logic [63:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (r_out_valid && if_id_ready)  r_perf_fetched <= r_perf_fetched + 64'd1;
      if (r_out_valid && !if_id_ready) r_perf_stall   <= r_perf_stall + 64'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model pushes expected items, monitor pops on ID handshakes.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ibus_req_valid;
  logic [63:0] ibus_req_addr;
  logic        ibus_resp_valid;
  logic [31:0] ibus_resp_data;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_id_valid;
  logic        if_id_ready = 1'b1;
  if_id_t      if_id_state;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_stall;
`endif

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ibus_req_valid  (ibus_req_valid),
    .ibus_req_addr   (ibus_req_addr),
    .ibus_resp_valid (ibus_resp_valid),
    .ibus_resp_data  (ibus_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_id_valid     (if_id_valid),
    .if_id_ready     (if_id_ready),
    .if_id_state     (if_id_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  if_id_t      sb_q[$];
  if_id_t      dl_q[$];
  int          dl_cyc[$];
  logic [63:0] rq_log[$];

  int mem_lat   = 1;
  int mem_cnt   = 0;
  int mem_limit = 1000000;
  int mem_issued = 0;
  logic mem_discard = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a, 16'h0013};
  endfunction

  // Memory: answers each request mem_lat cycles after it appears; expected items pushed at issue
  initial begin
    ibus_resp_valid = 1'b0;
    ibus_resp_data  = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (rst) #2;
      if (!rst) begin
        ibus_resp_valid = 1'b0;
        mem_cnt         = 0;
        mem_discard     = 1'b0;
      end else begin
        if (ibus_resp_valid) begin
          ibus_resp_valid = 1'b0;
          mem_cnt         = 0;
        end
        if (ibus_req_valid && mem_issued < mem_limit) begin
          if (mem_cnt < mem_lat) begin
            mem_cnt++;
            if (redirect_valid) mem_discard = 1'b1;
          end else begin
            ibus_resp_valid = 1'b1;
            ibus_resp_data  = mem_word(ibus_req_addr[15:0]);
            mem_issued++;
            if (!redirect_valid && !mem_discard)
              sb_q.push_back('{pc: ibus_req_addr, inst: mem_word(ibus_req_addr[15:0])});
            mem_discard = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: handshake pops, stall stability and bus-hold checks, request logging
  logic   p_stall = 1'b0;
  logic   p_hold  = 1'b0;
  if_id_t p_state;
  logic [63:0] p_addr;
  if_id_t exp_item;
  int     cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        sb_q.delete();
        p_stall = 1'b0;
        p_hold  = 1'b0;
      end else begin
        if (p_stall) begin
          chk("stall_valid", 64'(if_id_valid), 64'd1);
          chk("stall_state", if_id_state.pc ^ 64'(if_id_state.inst), p_state.pc ^ 64'(p_state.inst));
        end
        if (p_hold) begin
          chk("req_held", 64'(ibus_req_valid), 64'd1);
          chk("req_addr_stable", ibus_req_addr, p_addr);
        end else if (ibus_req_valid) begin
          rq_log.push_back(ibus_req_addr);
        end
        if (if_id_valid && if_id_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got pc %h inst %h expected none", if_id_state.pc, if_id_state.inst);
          end else begin
            exp_item = sb_q.pop_front();
            chk("deliv_pc", if_id_state.pc, exp_item.pc);
            chk("deliv_inst", 64'(if_id_state.inst), 64'(exp_item.inst));
          end
          dl_q.push_back(if_id_state);
          dl_cyc.push_back(cyc);
        end
        if (redirect_valid) sb_q.delete();
        p_stall = if_id_valid && !if_id_ready && !redirect_valid;
        p_hold  = ibus_req_valid && !ibus_resp_valid;
        p_state = if_id_state;
        p_addr  = ibus_req_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    if_id_ready    = ready;
    mem_lat        = 1;
    mem_limit      = 1000000;
    repeat (2) tick();
    rq_log.delete();
    dl_q.delete();
    dl_cyc.delete();
    mem_issued = 0;
    rst = 1'b1;
  endtask

  task automatic wait_deliv(input int n, input string nm);
    int k = 0;
    while (dl_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    if (dl_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d deliveries expected %0d", nm, dl_q.size(), n);
    end
  endtask

  task automatic wait_req(input logic [63:0] a, input string nm);
    int k = 0;
    while (!(ibus_req_valid && ibus_req_addr == a) && k < 300) begin
      tick();
      k++;
    end
    if (!(ibus_req_valid && ibus_req_addr == a)) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got addr %h expected %h", nm, ibus_req_addr, a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and sequential fetch
    do_reset(1'b1);
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 64'(ibus_req_valid), 64'd0);
    chk("rst_req_addr", ibus_req_addr, RPC);
    chk("rst_if_id_valid", 64'(if_id_valid), 64'd0);
    chk("rst_if_id_pc", if_id_state.pc, 64'd0);
    rst = 1'b1;
    wait_deliv(3, "seq");
    chk("seq_req0", rq_log[0], 64'h8000_0000);
    chk("seq_req1", rq_log[1], 64'h8000_0004);
    chk("seq_req2", rq_log[2], 64'h8000_0008);
    chk("seq_inst0", 64'(dl_q[0].inst), 64'h0000_0013);
    chk("seq_inst1", 64'(dl_q[1].inst), 64'h0004_0013);
    chk("seq_inst2", 64'(dl_q[2].inst), 64'h0008_0013);

    // Decoder stall: second word parks in the skid, fetch stops
    do_reset(1'b0);
    begin
      int k = 0;
      while (!if_id_valid && k < 50) begin
        tick();
        k++;
      end
    end
    repeat (5) tick();
    chk("stall_req_off", 64'(ibus_req_valid), 64'd0);
    chk("stall_out_valid", 64'(if_id_valid), 64'd1);
    chk("stall_out_pc", if_id_state.pc, RPC);
    chk("stall_out_inst", 64'(if_id_state.inst), 64'h0000_0013);
    if_id_ready = 1'b1;
    wait_deliv(2, "skid_drain");
    chk("drain_inst0", 64'(dl_q[0].inst), 64'h0000_0013);
    chk("drain_inst1", 64'(dl_q[1].inst), 64'h0004_0013);
    chk("drain_b2b", 64'(dl_cyc[1] - dl_cyc[0]), 64'd1);

    // Redirect while a slow request is outstanding: FLUSH then fetch target
    do_reset(1'b1);
    wait_req(64'h8000_0004, "flush_req1");
    mem_lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    chk("flush_req_held", 64'(ibus_req_valid), 64'd1);
    chk("flush_addr_held", ibus_req_addr, 64'h8000_0004);
    wait_req(64'h8000_1000, "flush_target");
    mem_lat = 1;
    wait_deliv(2, "flush_deliv");
    chk("flush_req_log", rq_log[2], 64'h8000_1000);
    chk("flush_deliv_pc", dl_q[1].pc, 64'h8000_1000);
    chk("flush_deliv_inst", 64'(dl_q[1].inst), 64'h1000_0013);

    // Redirect coincident with a response
    do_reset(1'b1);
    wait_req(64'h8000_0004, "cores_req1");
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    tick();
    redirect_valid = 1'b0;
    chk("cores_out_invalid", 64'(if_id_valid), 64'd0);
    chk("cores_req_valid", 64'(ibus_req_valid), 64'd1);
    chk("cores_req_addr", ibus_req_addr, 64'h8000_2000);
    wait_deliv(2, "cores_deliv");
    chk("cores_deliv_pc", dl_q[1].pc, 64'h8000_2000);
    chk("cores_deliv_inst", 64'(dl_q[1].inst), 64'h2000_0013);

    // Asynchronous reset in the middle of a request
    do_reset(1'b0);
    begin
      int k = 0;
      while (!if_id_valid && k < 50) begin
        tick();
        k++;
      end
    end
    rst = 1'b0;
    #1;
    chk("arst_req_valid", 64'(ibus_req_valid), 64'd0);
    chk("arst_req_addr", ibus_req_addr, RPC);
    chk("arst_out_valid", 64'(if_id_valid), 64'd0);
    chk("arst_out_state", if_id_state.pc ^ 64'(if_id_state.inst), 64'd0);
    tick();
    rq_log.delete();
    dl_q.delete();
    dl_cyc.delete();
    if_id_ready = 1'b1;
    rst = 1'b1;
    wait_deliv(1, "arst_refetch");
    chk("arst_first_req", rq_log[0], RPC);
    chk("arst_first_inst", 64'(dl_q[0].inst), 64'h0000_0013);

`ifdef FETCH_PERF_EN
    // Performance counters: 10 accepted, 4 stall cycles
    do_reset(1'b1);
    chk("perf_rst_fetched", perf_fetched, 64'd0);
    chk("perf_rst_stall", perf_stall, 64'd0);
    mem_limit = 10;
    begin
      int stalls_left = 4;
      int k = 0;
      while (dl_q.size() < 10 && k < 400) begin
        if (dl_q.size() >= 2 && stalls_left > 0 && if_id_valid) begin
          if_id_ready = 1'b0;
          stalls_left--;
        end else begin
          if_id_ready = 1'b1;
        end
        tick();
        k++;
      end
    end
    if_id_ready = 1'b1;
    repeat (3) tick();
    chk("perf_fetched", perf_fetched, 64'd10);
    chk("perf_stall", perf_stall, 64'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
